// File: rtl/dds_cmd_parser.sv
// Byte-stream command parser: fetches bytes from the command FIFO and loads the
// DDS tuning/phase/enable registers. Define DDS_PARSER_CHECKSUM_EN for 7-byte checksummed frames.
module dds_cmd_parser #(
  parameter int TIMEOUT = 50000,
  parameter int POW_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fifo_rd,
  input  logic             fifo_rd_done,
  input  logic [7:0]       fifo_dout,
  output logic [31:0]      ftw,
  output logic [POW_W-1:0] pow,
  output logic             out_en,
  output logic             update,
  output logic             frame_err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {F_REQ, F_ACK, F_DATA} fetch_t;
  typedef enum logic [2:0] {
    HUNT, S_CMD, S_D3, S_D2, S_D1, S_D0
`ifdef DDS_PARSER_CHECKSUM_EN
    , S_CHK
`endif
  } frame_t;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  fetch_t             fetch_q, fetch_d;
  frame_t             frame_q, frame_d;
  logic               fifo_rd_q, fifo_rd_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [31:0]        pay_q, pay_d;
  logic [31:0]        tmo_q, tmo_d;
  logic [31:0]        ftw_q, ftw_d;
  logic [POW_W-1:0]   pow_q, pow_d;
  logic               out_en_q, out_en_d;
  logic               update_q, update_d;
  logic               frame_err_q, frame_err_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic               byte_vld;
  logic               do_eval;
  logic               chk_ok;
  logic [31:0]        word;
  logic [31:0]        eval_word;
`ifdef DDS_PARSER_CHECKSUM_EN
  logic [7:0]         chk_q, chk_d;
`endif

  // Fetch handshake: one outstanding read, byte taken when done rises again.
  always_comb begin
    fetch_d   = fetch_q;
    fifo_rd_d = 1'b0;
    byte_vld  = 1'b0;
    case (fetch_q)
      F_REQ: begin
        fifo_rd_d = 1'b1;
        fetch_d   = F_ACK;
      end
      F_ACK:  if (!fifo_rd_done) fetch_d = F_DATA;
      F_DATA: if (fifo_rd_done) begin
        byte_vld = 1'b1;
        fetch_d  = F_REQ;
      end
      default: fetch_d = F_REQ;
    endcase
  end

  always_comb begin
    frame_d     = frame_q;
    cmd_d       = cmd_q;
    pay_d       = pay_q;
    tmo_d       = tmo_q;
    ftw_d       = ftw_q;
    pow_d       = pow_q;
    out_en_d    = out_en_q;
    update_d    = 1'b0;
    frame_err_d = 1'b0;
    do_eval     = 1'b0;
    chk_ok      = 1'b1;
    word        = {pay_q[23:0], fifo_dout};
    eval_word   = word;
`ifdef DDS_PARSER_CHECKSUM_EN
    chk_d       = chk_q;
    eval_word   = pay_q;
`endif

    if (byte_vld) begin
      tmo_d = 32'd0;
      case (frame_q)
        HUNT:  if (fifo_dout == 8'hA5) frame_d = S_CMD;
        S_CMD: begin
          cmd_d   = fifo_dout;
          frame_d = S_D3;
`ifdef DDS_PARSER_CHECKSUM_EN
          chk_d   = fifo_dout;
`endif
        end
        S_D3, S_D2, S_D1: begin
          pay_d   = word;
          frame_d = frame_t'(frame_q + 3'd1);
`ifdef DDS_PARSER_CHECKSUM_EN
          chk_d   = chk_q ^ fifo_dout;
`endif
        end
        S_D0: begin
          pay_d = word;
`ifdef DDS_PARSER_CHECKSUM_EN
          chk_d   = chk_q ^ fifo_dout;
          frame_d = S_CHK;
`else
          frame_d = HUNT;
          do_eval = 1'b1;
`endif
        end
`ifdef DDS_PARSER_CHECKSUM_EN
        S_CHK: begin
          frame_d = HUNT;
          do_eval = 1'b1;
          chk_ok  = (fifo_dout == chk_q);
        end
`endif
        default: frame_d = HUNT;
      endcase
    end else if (frame_q == HUNT) begin
      tmo_d = 32'd0;
    end else if (TIMEOUT != 0) begin
      // Stalled frame: drop it but leave the outstanding fetch in flight.
      if (tmo_q == TMO_LAST) begin
        frame_d     = HUNT;
        frame_err_d = 1'b1;
        tmo_d       = 32'd0;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end

    if (do_eval) begin
      if (!chk_ok) begin
        frame_err_d = 1'b1;
      end else begin
        case (cmd_q)
          8'h01: begin ftw_d    = eval_word;              update_d = 1'b1; end
          8'h02: begin pow_d    = eval_word[POW_W-1:0];   update_d = 1'b1; end
          8'h03: begin out_en_d = eval_word[0];           update_d = 1'b1; end
          default: frame_err_d = 1'b1;
        endcase
      end
    end

    err_cnt_d = err_cnt_q;
    if (frame_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_q     <= F_REQ;
      frame_q     <= HUNT;
      fifo_rd_q   <= 1'b0;
      cmd_q       <= 8'd0;
      pay_q       <= 32'd0;
      tmo_q       <= 32'd0;
      ftw_q       <= 32'd0;
      pow_q       <= '0;
      out_en_q    <= 1'b0;
      update_q    <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'd0;
`ifdef DDS_PARSER_CHECKSUM_EN
      chk_q       <= 8'd0;
`endif
    end else begin
      fetch_q     <= fetch_d;
      frame_q     <= frame_d;
      fifo_rd_q   <= fifo_rd_d;
      cmd_q       <= cmd_d;
      pay_q       <= pay_d;
      tmo_q       <= tmo_d;
      ftw_q       <= ftw_d;
      pow_q       <= pow_d;
      out_en_q    <= out_en_d;
      update_q    <= update_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
`ifdef DDS_PARSER_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign fifo_rd   = fifo_rd_q;
  assign ftw       = ftw_q;
  assign pow       = pow_q;
  assign out_en    = out_en_q;
  assign update    = update_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_dds_cmd_parser.sv
// Directed bench for dds_cmd_parser with a behavioural strobe/done FIFO model.
// Works with or without DDS_PARSER_CHECKSUM_EN.
module tb_dds_cmd_parser;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_rd;
  logic        fifo_rd_done = 1'b1;
  logic [7:0]  fifo_dout = 8'd0;
  logic [31:0] ftw;
  logic [15:0] pow;
  logic        out_en, update, frame_err;
  logic [7:0]  err_cnt;

  dds_cmd_parser #(.TIMEOUT(TMO), .POW_W(16)) dut (
    .clk(clk), .rst(rst), .fifo_rd(fifo_rd), .fifo_rd_done(fifo_rd_done),
    .fifo_dout(fifo_dout), .ftw(ftw), .pow(pow), .out_en(out_en),
    .update(update), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  bit pending = 1'b0;
  int cyc = 0, deliver_cyc = 0, err_cyc = 0;
  int upd_n = 0, ferr_n = 0, both_n = 0;
  int n_vec = 0, n_err = 0;

  always @(posedge clk) cyc++;

  // FIFO updates on the falling edge; pulse monitors share the same edge.
  always @(negedge clk) begin
    if (rst) begin
      pending = 1'b0;
      fifo_rd_done = 1'b1;
    end else if (fifo_rd) begin
      pending = 1'b1;
      fifo_rd_done = 1'b0;
    end else if (pending && q.size() != 0) begin
      fifo_dout = q.pop_front();
      fifo_rd_done = 1'b1;
      pending = 1'b0;
      deliver_cyc = cyc;
    end
    if (!rst) begin
      if (update) upd_n++;
      if (frame_err) begin ferr_n++; err_cyc = cyc; end
      if (update && frame_err) both_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] p);
    q.push_back(8'hA5);
    q.push_back(cmd);
    q.push_back(p[31:24]);
    q.push_back(p[23:16]);
    q.push_back(p[15:8]);
    q.push_back(p[7:0]);
`ifdef DDS_PARSER_CHECKSUM_EN
    q.push_back(cmd ^ p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0]);
`endif
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, q.size(), 0);
    repeat (8) @(negedge clk);
  endtask

  int u0, e0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_ftw", ftw, 0);
    chk("rst_pow", pow, 0);
    chk("rst_out_en", out_en, 0);
    chk("rst_update", update, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("first_fifo_rd", fifo_rd, 1);

    // valid FTW frame
    u0 = upd_n; e0 = ferr_n;
    send_frame(8'h01, 32'h12345678);
    drain("drain_ftw");
    chk("ftw_val", ftw, 32'h12345678);
    chk("ftw_upd", upd_n - u0, 1);
    chk("ftw_errcnt", err_cnt, 0);

    // bad frame: pow must be untouched
    u0 = upd_n; e0 = ferr_n;
`ifdef DDS_PARSER_CHECKSUM_EN
    q.push_back(8'hA5); q.push_back(8'h02); q.push_back(8'h00); q.push_back(8'h00);
    q.push_back(8'h12); q.push_back(8'h34); q.push_back(8'h00);
`else
    send_frame(8'h55, 32'h00001234);
`endif
    drain("drain_bad");
    chk("bad_errcnt", err_cnt, 1);
    chk("bad_pulse", ferr_n - e0, 1);
    chk("bad_pow", pow, 0);
    chk("bad_noupd", upd_n - u0, 0);

    // junk before sync
    u0 = upd_n;
    q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h5A);
    send_frame(8'h03, 32'h00000001);
    drain("drain_junk");
    chk("junk_out_en", out_en, 1);
    chk("junk_upd", upd_n - u0, 1);
    chk("junk_errcnt", err_cnt, 1);

    // pow truncation and 0xA5 inside payload
    send_frame(8'h02, 32'hDEADBEEF);
    send_frame(8'h01, 32'hA5A5A5A5);
    drain("drain_pow");
    chk("pow_trunc", pow, 16'hBEEF);
    chk("ftw_a5_data", ftw, 32'hA5A5A5A5);

    // stalled frame and timeout timing
    e0 = ferr_n;
    q.push_back(8'hA5); q.push_back(8'h01); q.push_back(8'h00);
    drain("drain_stall");
    repeat (25) @(negedge clk);
    chk("tmo_pulse", ferr_n - e0, 1);
    chk("tmo_latency", err_cyc - deliver_cyc, TMO + 1);
    chk("tmo_errcnt", err_cnt, 2);
    send_frame(8'h01, 32'h0BADF00D);
    drain("drain_after_tmo");
    chk("tmo_next_ftw", ftw, 32'h0BADF00D);
    chk("tmo_next_errcnt", err_cnt, 2);

    // unknown command consumes full frame
    u0 = upd_n;
    send_frame(8'h07, 32'h00000000);
    send_frame(8'h03, 32'hFFFFFFFE);
    drain("drain_unk");
    chk("unk_errcnt", err_cnt, 3);
    chk("unk_out_en", out_en, 0);
    chk("unk_upd", upd_n - u0, 1);

    // reset mid-frame
    q.push_back(8'hA5); q.push_back(8'h01); q.push_back(8'h12);
    drain("drain_partial");
    rst = 1'b1;
    #1;
    chk("mid_rst_ftw", ftw, 0);
    chk("mid_rst_pow", pow, 0);
    chk("mid_rst_errcnt", err_cnt, 0);
    chk("mid_rst_fifo_rd", fifo_rd, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    e0 = ferr_n;
    send_frame(8'h01, 32'h00000010);
    drain("drain_post_rst");
    chk("post_rst_ftw", ftw, 32'h00000010);
    chk("post_rst_errcnt", err_cnt, 0);
    chk("post_rst_noerr", ferr_n - e0, 0);

    // saturation
    for (int i = 0; i < 254; i++) send_frame(8'h09, i);
    drain("drain_sat254");
    chk("sat_254", err_cnt, 8'hFE);
    for (int i = 0; i < 3; i++) send_frame(8'h00, i);
    drain("drain_sat");
    chk("sat_ff", err_cnt, 8'hFF);

    chk("never_both", both_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
